// File: rtl/tgif_ks_pkg.sv
// tgif_ks_pkg: shared types, constants and the TGIF key-update step functions.
//   key_t      128-bit key, word W0 in [127:96] down to W3 in [31:0]
//   word_t     32-bit word
//   ks_state_e sequencer state encoding
//   rotl8      rotate a word left by 8
//   ks_fwd     one forward key-update step F
//   ks_inv     one inverse key-update step G, G(F(x)) == x
package tgif_ks_pkg;

  typedef logic [127:0] key_t;
  typedef logic [31:0]  word_t;

  localparam word_t RCON_DEFAULT = 32'h0101_0000;

  typedef enum logic [0:0] {
    KS_IDLE = 1'b0,
    KS_EMIT = 1'b1
  } ks_state_e;

  function automatic word_t rotl8(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic key_t ks_fwd(input key_t k, input word_t rcon);
    word_t w0, w1, w2, w3, n0, n1, n2, n3;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    n0 = w0 ^ w1 ^ rotl8(w3) ^ rcon;
    n1 = w1 ^ w2 ^ rotl8(n0) ^ rcon;
    n2 = w2 ^ w3 ^ rotl8(n1) ^ rcon;
    n3 = w3 ^ n0 ^ rotl8(n2) ^ rcon;
    return {n0, n1, n2, n3};
  endfunction

  // Undoes ks_fwd by peeling the words off in reverse order: W3 first
  // (needs only n0/n2/n3), then W2, W1 and finally W0.
  function automatic key_t ks_inv(input key_t k, input word_t rcon);
    word_t w0, w1, w2, w3, n0, n1, n2, n3;
    n0 = k[127:96];
    n1 = k[95:64];
    n2 = k[63:32];
    n3 = k[31:0];
    w3 = n3 ^ n0 ^ rotl8(n2) ^ rcon;
    w2 = n2 ^ w3 ^ rotl8(n1) ^ rcon;
    w1 = n1 ^ w2 ^ rotl8(n0) ^ rcon;
    w0 = n0 ^ w1 ^ rotl8(w3) ^ rcon;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/keysched_step.sv
// keysched_step: one combinational TGIF key-update step.
//   key_in   key before the step
//   dir      0 = forward step F, 1 = inverse step G
//   key_out  key after the step
module keysched_step
  import tgif_ks_pkg::*;
#(
  parameter word_t RCON = RCON_DEFAULT
) (
  input  key_t key_in,
  input  logic dir,
  output key_t key_out
);

  assign key_out = dir ? ks_inv(key_in, RCON) : ks_fwd(key_in, RCON);

endmodule

// File: rtl/keysched_seq.sv
// keysched_seq: sequential TGIF round-key generator.
// Loads a master key, then streams ROUNDS round keys over valid/ready,
// advancing the key register by STEPS update steps per accepted key.
//   clk, rst              clock, asynchronous active-high reset
//   load_valid/load_ready master-key load handshake (ready only when idle)
//   key_in, dir           master key and direction, captured with the load
//   abort                 synchronous cancel, wins over any handshake
//   rk_valid/rk_ready     round-key handshake
//   rk_out, rk_idx        round key and its index 0..ROUNDS-1
//   rk_last               rk_out is the final key of the run
//   key_state             key register; post-final state after a full run
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for a load, load_ready=1, rk_valid=0
// EMIT    | presenting key_reg as round key idx, rk_valid=1
module keysched_seq
  import tgif_ks_pkg::*;
#(
  parameter int    ROUNDS = 8,
  parameter int    STEPS  = 1,
  parameter word_t RCON   = RCON_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  key_t                      key_in,
  input  logic                      dir,
  input  logic                      abort,
  output logic                      rk_valid,
  input  logic                      rk_ready,
  output key_t                      rk_out,
  output logic [$clog2(ROUNDS)-1:0] rk_idx,
  output logic                      rk_last,
  output key_t                      key_state
);

  localparam int IW = $clog2(ROUNDS);
  localparam logic [IW-1:0] IDX_LAST = IW'(ROUNDS - 1);

  localparam logic [0:0] S_IDLE = KS_IDLE;
  localparam logic [0:0] S_EMIT = KS_EMIT;

  if (ROUNDS < 2) begin : g_bad_rounds
    $error("keysched_seq: ROUNDS must be >= 2");
  end
  if (STEPS < 1) begin : g_bad_steps
    $error("keysched_seq: STEPS must be >= 1");
  end

  logic [0:0]    state_q;
  key_t          key_q;
  logic [IW-1:0] idx_q;
  logic          dir_q;
  logic          is_last;

  // Unrolled advance chain: chain[STEPS] = A(key_q) for the latched direction.
  key_t chain [STEPS+1];
  assign chain[0] = key_q;

  for (genvar g = 0; g < STEPS; g++) begin : g_step
    keysched_step #(
      .RCON(RCON)
    ) u_step (
      .key_in (chain[g]),
      .dir    (dir_q),
      .key_out(chain[g+1])
    );
  end

  assign is_last = (idx_q == IDX_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      dir_q   <= 1'b0;
    end else if (abort) begin
      // key_q deliberately untouched so the interrupted state stays visible
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else if (state_q == S_IDLE) begin
      if (load_valid) begin
        key_q   <= key_in;
        idx_q   <= '0;
        dir_q   <= dir;
        state_q <= S_EMIT;
      end
    end else begin
      if (rk_ready) begin
        key_q <= chain[STEPS];
        if (is_last) begin
          state_q <= S_IDLE;
          idx_q   <= '0;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

  assign load_ready = (state_q == S_IDLE);
  assign rk_valid   = (state_q == S_EMIT);
  assign rk_out     = key_q;
  assign rk_idx     = idx_q;
  assign rk_last    = rk_valid && is_last;
  assign key_state  = key_q;

endmodule

// File: tb/tb_keysched_seq.sv
// tb_keysched_seq: scoreboard bench for keysched_seq.
// Instance a: ROUNDS=4, STEPS=1. Instance b: ROUNDS=8, STEPS=2 (round trip).
module tb_keysched_seq;

  localparam logic [31:0]  C  = 32'h0101_0000;
  localparam logic [127:0] H1 = 128'h01010000_00010001_00010100_01010000;

  typedef struct {
    logic [127:0] key;
    int           idx;
    logic         last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         a_load_valid = 1'b0, a_load_ready, a_dir = 1'b0, a_abort = 1'b0;
  logic         a_rk_valid, a_rk_ready = 1'b0, a_rk_last;
  logic [127:0] a_key_in = '0, a_rk_out, a_key_state;
  logic [1:0]   a_rk_idx;

  logic         b_load_valid = 1'b0, b_load_ready, b_dir = 1'b0, b_abort = 1'b0;
  logic         b_rk_valid, b_rk_ready = 1'b0, b_rk_last;
  logic [127:0] b_key_in = '0, b_rk_out, b_key_state;
  logic [2:0]   b_rk_idx;

  keysched_seq #(.ROUNDS(4), .STEPS(1), .RCON(C)) dut_a (
    .clk(clk), .rst(rst), .load_valid(a_load_valid), .load_ready(a_load_ready),
    .key_in(a_key_in), .dir(a_dir), .abort(a_abort), .rk_valid(a_rk_valid),
    .rk_ready(a_rk_ready), .rk_out(a_rk_out), .rk_idx(a_rk_idx),
    .rk_last(a_rk_last), .key_state(a_key_state)
  );

  keysched_seq #(.ROUNDS(8), .STEPS(2), .RCON(C)) dut_b (
    .clk(clk), .rst(rst), .load_valid(b_load_valid), .load_ready(b_load_ready),
    .key_in(b_key_in), .dir(b_dir), .abort(b_abort), .rk_valid(b_rk_valid),
    .rk_ready(b_rk_ready), .rk_out(b_rk_out), .rk_idx(b_rk_idx),
    .rk_last(b_rk_last), .key_state(b_key_state)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t qa[$];
  exp_t qb[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model, word-array formulation.
  function automatic logic [31:0] r8(input logic [31:0] w);
    return (w << 8) | (w >> 24);
  endfunction

  function automatic logic [127:0] mf(input logic [127:0] k);
    logic [31:0] w[4];
    logic [31:0] n[4];
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    n[0] = w[0] ^ w[1] ^ r8(w[3]) ^ C;
    for (int i = 1; i < 3; i++) n[i] = w[i] ^ w[i+1] ^ r8(n[i-1]) ^ C;
    n[3] = w[3] ^ n[0] ^ r8(n[2]) ^ C;
    return {n[0], n[1], n[2], n[3]};
  endfunction

  function automatic logic [127:0] mg(input logic [127:0] k);
    logic [31:0] n[4];
    logic [31:0] w[4];
    for (int i = 0; i < 4; i++) n[i] = k[127-32*i -: 32];
    w[3] = n[3] ^ n[0] ^ r8(n[2]) ^ C;
    for (int i = 2; i >= 1; i--) w[i] = n[i] ^ w[i+1] ^ r8(n[i-1]) ^ C;
    w[0] = n[0] ^ w[1] ^ r8(w[3]) ^ C;
    return {w[0], w[1], w[2], w[3]};
  endfunction

  function automatic logic [127:0] rkey();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitors: a handshake is seen at the negedge before the edge that takes it.
  always @(negedge clk) begin
    if (!rst && !a_abort && a_rk_valid && a_rk_ready) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_key", 128'(a_rk_idx), 128'hFFFF);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_rk_out", a_rk_out, e.key);
        chk("a_rk_idx", 128'(a_rk_idx), 128'(e.idx));
        chk("a_rk_last", 128'(a_rk_last), 128'(e.last));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && !b_abort && b_rk_valid && b_rk_ready) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_key", 128'(b_rk_idx), 128'hFFFF);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_rk_out", b_rk_out, e.key);
        chk("b_rk_idx", 128'(b_rk_idx), 128'(e.idx));
        chk("b_rk_last", 128'(b_rk_last), 128'(e.last));
      end
    end
  end

  task automatic push_a(input logic [127:0] key, input logic d, output logic [127:0] fin);
    logic [127:0] k;
    k = key;
    for (int i = 0; i < 4; i++) begin
      qa.push_back('{k, i, (i == 3)});
      k = d ? mg(k) : mf(k);
    end
    fin = k;
  endtask

  task automatic load_a(input logic [127:0] key, input logic d);
    int c;
    c = 0;
    while (!a_load_ready && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    chk("a_load_wait", 128'(a_load_ready), 128'(1));
    a_load_valid = 1'b1;
    a_key_in     = key;
    a_dir        = d;
    @(posedge clk); #1;
    a_load_valid = 1'b0;
  endtask

  // Returns one cycle after the final handshake has been taken.
  task automatic drain_a(input bit rnd);
    int cyc;
    cyc = 0;
    a_rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    while (qa.size() != 0 && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      a_rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    if (qa.size() != 0) begin
      chk("a_drain_timeout", 128'(qa.size()), 128'(0));
      qa.delete();
    end
    chk("a_load_ready_after_last", 128'(a_load_ready), 128'(1));
    a_rk_ready = 1'b0;
  endtask

  task automatic load_b(input logic [127:0] key, input logic d);
    int c;
    c = 0;
    while (!b_load_ready && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    chk("b_load_wait", 128'(b_load_ready), 128'(1));
    b_load_valid = 1'b1;
    b_key_in     = key;
    b_dir        = d;
    @(posedge clk); #1;
    b_load_valid = 1'b0;
  endtask

  task automatic drain_b();
    int cyc;
    cyc = 0;
    b_rk_ready = 1'b1;
    while (qb.size() != 0 && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (qb.size() != 0) begin
      chk("b_drain_timeout", 128'(qb.size()), 128'(0));
      qb.delete();
    end
    chk("b_load_ready_after_last", 128'(b_load_ready), 128'(1));
    b_rk_ready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] k, fin, k1, k2;
    logic [127:0] fk[9];

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_load_ready", 128'(a_load_ready), 128'(1));
    chk("reset_rk_valid",   128'(a_rk_valid),   128'(0));
    chk("reset_key_state",  a_key_state,        128'(0));
    chk("reset_rk_idx",     128'(a_rk_idx),     128'(0));

    // Zero key forward, hand-computed first two keys
    qa.push_back('{128'h0, 0, 1'b0});
    qa.push_back('{H1, 1, 1'b0});
    k = mf(H1);
    qa.push_back('{k, 2, 1'b0});
    k = mf(k);
    qa.push_back('{k, 3, 1'b1});
    fin = mf(k);
    load_a(128'h0, 1'b0);
    chk("first_valid",     128'(a_rk_valid),   128'(1));
    chk("first_idx",       128'(a_rk_idx),     128'(0));
    chk("first_key",       a_rk_out,           128'h0);
    chk("emit_load_ready", 128'(a_load_ready), 128'(0));
    drain_a(1'b0);
    chk("fwd_zero_state", a_key_state, fin);

    // Inverse from the hand-computed key returns to zero at idx1
    qa.push_back('{H1, 0, 1'b0});
    qa.push_back('{128'h0, 1, 1'b0});
    k = mg(128'h0);
    qa.push_back('{k, 2, 1'b0});
    k = mg(k);
    qa.push_back('{k, 3, 1'b1});
    fin = mg(k);
    load_a(H1, 1'b1);
    drain_a(1'b0);
    chk("inv_state", a_key_state, fin);

    // Backpressure for 3 cycles at idx1
    k = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    push_a(k, 1'b0, fin);
    k1 = mf(k);
    load_a(k, 1'b0);
    a_rk_ready = 1'b1;
    @(posedge clk); #1;
    a_rk_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_valid", 128'(a_rk_valid), 128'(1));
      chk("bp_idx",   128'(a_rk_idx),   128'(1));
      chk("bp_key",   a_rk_out,         k1);
    end
    drain_a(1'b0);
    chk("bp_state", a_key_state, fin);

    // Random backpressure, random keys and directions
    for (int r = 0; r < 1000; r++) begin
      logic d;
      k = rkey();
      d = 1'($urandom_range(0, 1));
      push_a(k, d, fin);
      load_a(k, d);
      drain_a(1'b1);
      chk("rand_state", a_key_state, fin);
    end

    // Abort at idx2 with rk_ready high: no advance
    k  = rkey();
    k1 = mf(k);
    k2 = mf(k1);
    qa.push_back('{k, 0, 1'b0});
    qa.push_back('{k1, 1, 1'b0});
    load_a(k, 1'b0);
    a_rk_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_pre_idx", 128'(a_rk_idx), 128'(2));
    a_abort = 1'b1;
    @(posedge clk); #1;
    a_abort    = 1'b0;
    a_rk_ready = 1'b0;
    chk("abort_rk_valid",   128'(a_rk_valid),   128'(0));
    chk("abort_load_ready", 128'(a_load_ready), 128'(1));
    chk("abort_key_state",  a_key_state,        k2);
    chk("abort_queue",      128'(qa.size()),    128'(0));
    k = rkey();
    push_a(k, 1'b0, fin);
    load_a(k, 1'b0);
    drain_a(1'b0);
    chk("post_abort_state", a_key_state, fin);

    // Asynchronous reset mid-run at idx1
    k = rkey();
    push_a(k, 1'b0, fin);
    load_a(k, 1'b0);
    a_rk_ready = 1'b1;
    @(posedge clk); #1;
    a_rk_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_rk_valid",   128'(a_rk_valid),   128'(0));
    chk("rst_key_state",  a_key_state,        128'(0));
    chk("rst_load_ready", 128'(a_load_ready), 128'(1));
    chk("rst_rk_idx",     128'(a_rk_idx),     128'(0));
    qa.delete();
    #4 rst = 1'b0;
    @(posedge clk); #1;
    k = rkey();
    push_a(k, 1'b0, fin);
    load_a(k, 1'b0);
    drain_a(1'b0);
    chk("post_rst_state", a_key_state, fin);

    // Round trip, ROUNDS=8 STEPS=2
    fk[0] = rkey();
    for (int i = 0; i < 8; i++) fk[i+1] = mf(mf(fk[i]));
    for (int i = 0; i < 8; i++) qb.push_back('{fk[i], i, (i == 7)});
    load_b(fk[0], 1'b0);
    drain_b();
    chk("rt_fwd_state", b_key_state, fk[8]);
    for (int i = 0; i < 8; i++) qb.push_back('{fk[8-i], i, (i == 7)});
    load_b(b_key_state == fk[8] ? b_key_state : fk[8], 1'b1);
    drain_b();
    chk("rt_inv_state", b_key_state, fk[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keysched_seq.md
Name: keysched_seq

Overview:
- Sequential, parametrised TGIF round-key generator.
- Holds the 128-bit key state in a register and advances it by STEPS applications of the TGIF key-update step per emitted round key.
- Runs forward for encryption or inverse for decryption.
- Streams ROUNDS keys over a valid/ready interface to the round datapath.

Parameters:
- ROUNDS, 8: round keys emitted per run; must be >= 2.
- STEPS, 1: key-update steps applied between consecutive round keys (unroll depth, combinational chain); >= 1.
- RCON, 32'h01010000: 32-bit constant XORed into every word update.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- load_valid  in  1  master key offered.
- load_ready  out  1  block idle, accepts a load.
- key_in  in  128  master key (W0 = [127:96] .. W3 = [31:0]).
- dir  in  1  0 = forward, 1 = inverse; sampled with the load.
- abort  in  1  synchronous cancel of the current run.
- rk_valid  out  1  round key valid.
- rk_ready  in  1  consumer accepts the round key.
- rk_out  out  128  current round key.
- rk_idx  out  $clog2(ROUNDS)  index of rk_out, 0..ROUNDS-1.
- rk_last  out  1  rk_out is index ROUNDS-1.
- key_state  out  128  key register contents; after a completed run this is the post-final state.

Behaviour:
- rotl8(w) = {w[23:0], w[31:24]}.
- Forward step F(W0..W3):
  - n0 = W0^W1^rotl8(W3)^RCON
  - n1 = W1^W2^rotl8(n0)^RCON
  - n2 = W2^W3^rotl8(n1)^RCON
  - n3 = W3^n0^rotl8(n2)^RCON
- Inverse step G(n0..n3):
  - W3 = n3^n0^rotl8(n2)^RCON
  - W2 = n2^W3^rotl8(n1)^RCON
  - W1 = n1^W2^rotl8(n0)^RCON
  - W0 = n0^W1^rotl8(W3)^RCON
  - G(F(x)) = x is required.
- Advance function A = F^STEPS (dir=0) or G^STEPS (dir=1). dir is latched into dir_q at load.
- States:
  - IDLE: load_ready=1, rk_valid=0.
  - EMIT: load_ready=0, rk_valid=1.
- IDLE, load_valid&load_ready at cycle t:
  - key_reg <= key_in, idx <= 0, dir_q <= dir, -> EMIT.
  - rk_valid first high at t+1 with rk_idx=0 and rk_out=key_in.
- EMIT:
  - rk_out = key_reg, rk_last = (idx==ROUNDS-1).
  - On rk_valid&rk_ready: key_reg <= A(key_reg).
  - If not last, idx++; if last, -> IDLE, idx <= 0.
  - Throughput: one key per cycle while rk_ready is held high, no bubbles.
- Backpressure: with rk_ready=0, rk_out, rk_idx and rk_last stay stable and rk_valid stays high.
- Chaining: after a completed forward run, key_state = F^(ROUNDS*STEPS)(key_in). Loading that value with dir=1 yields keys k_N, k_{N-1}, .. k_1 (N = ROUNDS).
- load_valid in EMIT is ignored; no queuing.
- abort (any state) takes priority over the handshake:
  - Next cycle: IDLE, rk_valid=0, idx=0.
  - key_reg holds its value and is not advanced, even if a handshake occurs in the same cycle.
- rst (asynchronous, any time including mid-run): state=IDLE, key_reg=0, idx=0, dir_q=0, rk_valid=0.
  - load_ready is 1 after reset; loads while rst is high are ignored.
- Widths: all arithmetic is bitwise XOR/rotate. idx saturates at ROUNDS-1; no wrap.
- Elaboration error if ROUNDS<2 or STEPS<1.

Decomposition:
- Package tgif_ks_pkg holds:
  - typedef key_t (128 bit) and word_t (32 bit)
  - RCON default
  - functions rotl8, ks_fwd, ks_inv
  - state enum {KS_IDLE, KS_EMIT}
- Sub-module keysched_step (combinational: in key_t, dir -> out key_t), instantiated STEPS times in a chain by generate.
- keysched_seq contains only the FSM, index counter and key register.

Test Plan:
- ROUNDS=4, STEPS=1, key 0, dir=0, rk_ready=1:
  - keys at consecutive cycles: idx0 = 0; idx1 = 01010000_00010001_00010100_01010000; idx2/idx3 match the model.
  - rk_last only at idx3; load_ready high the cycle after the last handshake.
- Inverse: load 01010000_00010001_00010100_01010000 with dir=1 -> idx1 rk_out = 0.
- Backpressure:
  - Drop rk_ready for 3 cycles at idx1 -> rk_out/rk_idx held, no key skipped.
  - Random rk_ready over 1000 runs -> scoreboard matches the model.
- Abort at idx2 -> rk_valid low next cycle, key_state unchanged. A new load with random key gives idx0 = new key.
- Reset mid-run (rst pulsed asynchronously between clock edges at idx1) -> rk_valid=0 and key_state=0 immediately; clean run afterwards.
- Round trip with ROUNDS=8, STEPS=2:
  - Forward random key, then load key_state with dir=1.
  - Inverse sequence equals the forward keys idx 1..7 plus the final state, in reverse order.
